// File: rtl/memory_banked.sv
// Banked program/data memory with a delayed DM write pipeline and a hardware DM clear engine.
// Optional write-to-read forwarding is enabled by defining MEM_BYPASS_EN.
module memory_banked #(
  parameter int PMA_SIZE     = 16,
  parameter int PMD_SIZE     = 32,
  parameter int DMA_SIZE     = 16,
  parameter int DMD_SIZE     = 16,
  parameter int DM_BANK_BITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ps_pm_cslt,
  input  logic                ps_pm_wrb,
  input  logic [PMA_SIZE-1:0] ps_pm_add,
  input  logic [PMD_SIZE-1:0] ps_pm_dt,
  output logic [PMD_SIZE-1:0] pm_ps_op,
  input  logic                ps_dm_cslt,
  input  logic                ps_dm_wrb,
  input  logic [DMA_SIZE-1:0] dg_dm_add,
  input  logic [DMD_SIZE-1:0] bc_dt,
  output logic [DMD_SIZE-1:0] dm_bc_dt,
  input  logic                ps_mem_clr,
  output logic                mem_ps_rdy
);

  localparam int ROW_BITS = DMA_SIZE - DM_BANK_BITS;
  localparam int BANKS    = 1 << DM_BANK_BITS;
  localparam int ROWS     = 1 << ROW_BITS;
  localparam int PM_DEPTH = 1 << PMA_SIZE;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_next_s;
  logic [ROW_BITS-1:0]   cnt_r;
  logic [ROW_BITS-1:0]   cnt_next_s;
  logic                  rdy_next_s;
  logic                  run_s;
  logic                  pm_rd_s;
  logic                  pm_wr_s;
  logic                  dm_rd_s;
  logic                  dm_wr_s;
  logic                  pend_v_r;
  logic [DMA_SIZE-1:0]   pend_add_r;
  logic [DMD_SIZE-1:0]   dm_rd_data_s;
  logic [DMD_SIZE-1:0]   bank_rd_s [0:BANKS-1];
  logic [PMD_SIZE-1:0]   pm_mem [0:PM_DEPTH-1];

  // Low address bits pick the bank, the rest pick the row (single bank when DM_BANK_BITS is 0).
  function automatic logic [ROW_BITS-1:0] row_of(input logic [DMA_SIZE-1:0] a);
    row_of = ROW_BITS'(a >> DM_BANK_BITS);
  endfunction

  function automatic int bank_of(input logic [DMA_SIZE-1:0] a);
    bank_of = int'(a) & (BANKS - 1);
  endfunction

  // Next-state logic: sweep rows while clearing, accept accesses only in RUN without a clear request
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    rdy_next_s   = 1'b0;
    run_s        = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        if (cnt_r == ROW_BITS'(ROWS - 1)) begin
          state_next_s = ST_RUN;
          cnt_next_s   = {ROW_BITS{1'b0}};
          rdy_next_s   = 1'b1;
        end else begin
          cnt_next_s   = cnt_r + ROW_BITS'(1);
        end
      end
      ST_RUN: begin
        if (ps_mem_clr) begin
          state_next_s = ST_CLEAR;
        end else begin
          rdy_next_s   = 1'b1;
          run_s        = 1'b1;
        end
      end
      default: begin
        state_next_s = ST_CLEAR;
        cnt_next_s   = {ROW_BITS{1'b0}};
      end
    endcase
  end

  assign pm_rd_s = run_s & ps_pm_cslt & ~ps_pm_wrb;
  assign pm_wr_s = run_s & ps_pm_cslt &  ps_pm_wrb;
  assign dm_rd_s = run_s & ps_dm_cslt & ~ps_dm_wrb;
  assign dm_wr_s = run_s & ps_dm_cslt &  ps_dm_wrb;

  // One storage array per DM bank; the clear sweep zeroes the same row in every bank at once
  for (genvar g = 0; g < BANKS; g++) begin : g_bank
    logic [DMD_SIZE-1:0] mem [0:ROWS-1];

    // Bank write port: a pending commit can never coincide with a sweep edge, so the priority is moot
    always_ff @(posedge clk) begin
      if (state_r == ST_CLEAR) begin
        mem[cnt_r] <= {DMD_SIZE{1'b0}};
      end else if (pend_v_r && (bank_of(pend_add_r) == g)) begin
        mem[row_of(pend_add_r)] <= bc_dt;
      end
    end

    assign bank_rd_s[g] = mem[row_of(dg_dm_add)];
  end

  // DM read data source, optionally forwarding the word being committed this edge
  always_comb begin
    dm_rd_data_s = bank_rd_s[bank_of(dg_dm_add)];
`ifdef MEM_BYPASS_EN
    if (pend_v_r && (pend_add_r == dg_dm_add)) begin
      dm_rd_data_s = bc_dt;
    end else begin
      dm_rd_data_s = bank_rd_s[bank_of(dg_dm_add)];
    end
`endif
  end

  // PM write port
  always_ff @(posedge clk) begin
    if (pm_wr_s) begin
      pm_mem[ps_pm_add] <= ps_pm_dt;
    end
  end

  // Control state, write pipeline and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_CLEAR;
      cnt_r      <= {ROW_BITS{1'b0}};
      mem_ps_rdy <= 1'b0;
      pend_v_r   <= 1'b0;
      pend_add_r <= {DMA_SIZE{1'b0}};
      pm_ps_op   <= {PMD_SIZE{1'b0}};
      dm_bc_dt   <= {DMD_SIZE{1'b0}};
    end else begin
      state_r    <= state_next_s;
      cnt_r      <= cnt_next_s;
      mem_ps_rdy <= rdy_next_s;
      pend_v_r   <= dm_wr_s;
      if (dm_wr_s) begin
        pend_add_r <= dg_dm_add;
      end
      if (pm_rd_s) begin
        pm_ps_op <= pm_mem[ps_pm_add];
      end
      if (dm_rd_s) begin
        dm_bc_dt <= dm_rd_data_s;
      end
    end
  end

endmodule

// File: doc/memory_banked.md
# memory_banked

Parametrised successor to the processor's PM/DM memory block. It provides a writable program memory and a banked data memory with a delayed (execute+1) write pipeline and optional write-to-read forwarding. A hardware clear engine zeroes DM after reset or on request and signals readiness to the program sequencer. It sits between the program sequencer (ps), DAG (dg) and bus connect (bc), replacing file-initialised memory with fully synthesisable behaviour.

## Interface
Parameters:
- PMA_SIZE, 16: PM address width; depth 2**PMA_SIZE.
- PMD_SIZE, 32: PM word width.
- DMA_SIZE, 16: DM address width; depth 2**DMA_SIZE.
- DMD_SIZE, 16: DM word width.
- DM_BANK_BITS, 2: log2 of DM bank count; legal range 0..DMA_SIZE-1. Bank = dg_dm_add[DM_BANK_BITS-1:0], row = upper bits. Value 0 means a single bank with row = full address.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ps_pm_cslt  in  1  PM chip select.
- ps_pm_wrb  in  1  PM direction: 1 = write, 0 = read.
- ps_pm_add  in  PMA_SIZE  PM address.
- ps_pm_dt  in  PMD_SIZE  PM write data.
- pm_ps_op  out  PMD_SIZE  PM read data, registered.
- ps_dm_cslt  in  1  DM chip select.
- ps_dm_wrb  in  1  DM direction: 1 = write, 0 = read.
- dg_dm_add  in  DMA_SIZE  DM address.
- bc_dt  in  DMD_SIZE  DM write data, sampled one cycle after the write request.
- dm_bc_dt  out  DMD_SIZE  DM read data, registered.
- ps_mem_clr  in  1  single-cycle request to re-zero DM.
- mem_ps_rdy  out  1  1 = RUN state; accesses are accepted.

## Operation
- Reset values: pm_ps_op = 0, dm_bc_dt = 0, mem_ps_rdy = 0, pending-write valid = 0, clear counter = 0, state = CLEAR. Array contents are not reset. PM contents are undefined until written.
- FSM has two states, CLEAR and RUN.
  - CLEAR: on each edge, writes 0 to row `cnt` of every DM bank in parallel and increments `cnt`. ROWS = 2**(DMA_SIZE-DM_BANK_BITS).
  - The edge that writes row ROWS-1 moves to RUN, sets mem_ps_rdy = 1 and resets `cnt` to 0.
  - RUN with ps_mem_clr = 1 moves to CLEAR on that edge and sets mem_ps_rdy = 0.
- In CLEAR, all cslt inputs are ignored, pm_ps_op and dm_bc_dt hold, and no new pending write is latched.
- PM read (RUN, cslt = 1, wrb = 0): pm_ps_op <= pm[ps_pm_add].
- PM write (RUN, cslt = 1, wrb = 1): pm[ps_pm_add] <= ps_pm_dt at the same edge. pm_ps_op holds.
- DM write is a two-edge operation.
  - Request edge E (RUN, cslt = 1, wrb = 1): latches pend_add and sets pend_v = 1.
  - Edge E+1: commits dm[pend_add] <= bc_dt, whatever the state or new request at E+1.
  - Back-to-back writes pipeline at one per cycle.
- DM read (RUN, cslt = 1, wrb = 0): dm_bc_dt <= dm[dg_dm_add], subject to forwarding (see Configuration). dm_bc_dt holds when no read occurs.
- ps_mem_clr sampled at edge E:
  - a pending write latched at E-1 still commits at E;
  - any PM/DM request presented in the same cycle is dropped;
  - the clear overwrites DM, including that committed word.
- ps_mem_clr in CLEAR: ignored; the sweep is not restarted.
- Reset asserted mid-sweep or mid-write: immediate return to reset values. A pending write is lost, and the sweep restarts from row 0 after release.

## Timing
- PM read latency: 1 cycle (data valid after the request edge).
- DM read latency: 1 cycle.
- DM write commit: the edge after the request. bc_dt must be valid in the cycle following the request.
- Clear duration: ROWS edges after reset release or after the ps_mem_clr edge. mem_ps_rdy rises on the ROWS-th edge. First access is accepted on the following edge.
- No combinational path from inputs to outputs.

## Configuration
- MEM_BYPASS_EN defined: a DM read at edge E+1 whose address equals the pending write address returns the bc_dt being committed at that edge.
- MEM_BYPASS_EN undefined: that read returns the array value before the commit (the old data). The new data is visible from the next read onward.

## Test plan
- Clear timing (DMA_SIZE = 4, DM_BANK_BITS = 2): release reset -> mem_ps_rdy = 0 for 3 edges, 1 after the 4th edge; read of every DM address returns 0.
- PM write/read: write 0xDEADBEEF to PM address 5, read address 5 next cycle -> pm_ps_op = 0xDEADBEEF one cycle later.
- Back-to-back DM writes: write 0x1111 to address 2 and 0x2222 to address 3, then read both -> 0x1111, 0x2222.
- Forwarding: write address 7 (bc_dt = 0xABCD next cycle) with a read of address 7 in that same following cycle -> dm_bc_dt = 0xABCD with MEM_BYPASS_EN, 0x0000 without.
- ps_mem_clr in RUN: after writing 0x5A5A to address 1, pulse clr -> mem_ps_rdy drops on the next edge, then after ROWS edges address 1 reads 0; a write requested in the clr cycle is discarded.
- Reset mid-clear: assert reset at sweep row 2 -> outputs return to 0 asynchronously; after release, mem_ps_rdy rises after exactly ROWS edges.
